// File: rtl/wb_unit.sv
// Write-back stage: drives the register-file write port from ALU results and multi-cycle loads.
// Optional WB_FORWARD_EN macro exports the write port as an EXE-stage bypass source.
module wb_unit #(
  parameter int LOAD_TIMEOUT = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             WB_EN,
  input  logic             MEM_R_EN,
  input  logic [3:0]       Dest,
  input  logic [31:0]      ALU_Res,
  input  logic             mem_valid,
  input  logic [31:0]      mem_rdata,
  output logic             writeBackEn,
  output logic [3:0]       Dest_wb,
  output logic [31:0]      Result_WB,
  output logic             load_err,
  output logic [CNT_W-1:0] wb_count
`ifdef WB_FORWARD_EN
  ,
  output logic             fwd_valid,
  output logic [3:0]       fwd_dest,
  output logic [31:0]      fwd_data
`endif
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  // Last wait cycle before the load is abandoned
  localparam logic [15:0] TMO_LAST = 16'(LOAD_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] tmo_q, tmo_d;
  logic [3:0]  ld_dest_q, ld_dest_d;
  logic        ld_wen_q, ld_wen_d;
  logic        we_d;
  logic [3:0]  dest_d;
  logic [31:0] data_d;
  logic        err_set;

  assign in_ready = (state_q == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      ld_dest_q   <= '0;
      ld_wen_q    <= 1'b0;
      writeBackEn <= 1'b0;
      Dest_wb     <= '0;
      Result_WB   <= '0;
      load_err    <= 1'b0;
      wb_count    <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      ld_dest_q   <= ld_dest_d;
      ld_wen_q    <= ld_wen_d;
      writeBackEn <= we_d;
      Dest_wb     <= dest_d;
      Result_WB   <= data_d;
      if (err_set) load_err <= 1'b1;
      if (writeBackEn) wb_count <= wb_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    ld_dest_d = ld_dest_q;
    ld_wen_d  = ld_wen_q;
    we_d      = 1'b0;
    dest_d    = Dest_wb;
    data_d    = Result_WB;
    err_set   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (MEM_R_EN) begin
            ld_dest_d = Dest;
            ld_wen_d  = WB_EN;
            tmo_d     = '0;
            state_d   = LOAD_WAIT;
          end else if (WB_EN) begin
            we_d   = 1'b1;
            dest_d = Dest;
            data_d = ALU_Res;
          end
        end
      end
      LOAD_WAIT: begin
        // Data arriving on the timeout edge takes priority over the abandon
        if (mem_valid) begin
          state_d = IDLE;
          if (ld_wen_q) begin
            we_d   = 1'b1;
            dest_d = ld_dest_q;
            data_d = mem_rdata;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef WB_FORWARD_EN
  assign fwd_valid = writeBackEn;
  assign fwd_dest  = Dest_wb;
  assign fwd_data  = Result_WB;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: per-cycle comparison against a transaction-level model
// plus hand-computed literal checks (LOAD_TIMEOUT=8, CNT_W=4).
module tb_wb_unit;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, WB_EN = 1'b0, MEM_R_EN = 1'b0, mem_valid = 1'b0;
  logic [3:0]  Dest = '0;
  logic [31:0] ALU_Res = '0, mem_rdata = '0;
  logic        in_ready, writeBackEn, load_err;
  logic [3:0]  Dest_wb, wb_count;
  logic [31:0] Result_WB;

  int vecs = 0;
  int errs = 0;

  wb_unit #(.LOAD_TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .Dest(Dest), .ALU_Res(ALU_Res),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .writeBackEn(writeBackEn),
    .Dest_wb(Dest_wb), .Result_WB(Result_WB), .load_err(load_err), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  // Model: a pending load is "busy" with an elapsed-wait count; every write is one pulse.
  logic        m_busy, m_lwen, m_we, m_err;
  int          m_waited;
  logic [3:0]  m_ldest, m_dest, m_cnt;
  logic [31:0] m_data;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_lwen <= 1'b0; m_we <= 1'b0; m_err <= 1'b0;
      m_waited <= 0; m_ldest <= '0; m_dest <= '0; m_cnt <= '0; m_data <= '0;
    end else begin
      m_cnt <= m_cnt + (m_we ? 4'd1 : 4'd0);
      m_we  <= 1'b0;
      if (!m_busy) begin
        if (in_valid && MEM_R_EN) begin
          m_busy <= 1'b1; m_waited <= 0; m_ldest <= Dest; m_lwen <= WB_EN;
        end else if (in_valid && WB_EN) begin
          m_we <= 1'b1; m_dest <= Dest; m_data <= ALU_Res;
        end
      end else if (mem_valid) begin
        m_busy <= 1'b0;
        if (m_lwen) begin m_we <= 1'b1; m_dest <= m_ldest; m_data <= mem_rdata; end
      end else if (m_waited + 1 == TMO) begin
        m_busy <= 1'b0; m_err <= 1'b1;
      end else begin
        m_waited <= m_waited + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [3:0] d, input logic [31:0] v, input logic wen);
    in_valid = 1'b1; MEM_R_EN = 1'b0; WB_EN = wen; Dest = d; ALU_Res = v;
    step();
    in_valid = 1'b0; WB_EN = 1'b0;
  endtask

  task automatic load(input logic [3:0] d, input logic wen);
    in_valid = 1'b1; MEM_R_EN = 1'b1; WB_EN = wen; Dest = d;
    step();
    in_valid = 1'b0; MEM_R_EN = 1'b0; WB_EN = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        chk("cyc_in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
        chk("cyc_we", {31'd0, writeBackEn}, {31'd0, m_we});
        chk("cyc_dest", {28'd0, Dest_wb}, {28'd0, m_dest});
        chk("cyc_data", Result_WB, m_data);
        chk("cyc_err", {31'd0, load_err}, {31'd0, m_err});
        chk("cyc_cnt", {28'd0, wb_count}, {28'd0, m_cnt});
      end
    join_none

    // Reset values
    #3;
    chk("rst_we", {31'd0, writeBackEn}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_data", Result_WB, 32'd0);
    chk("rst_cnt", {28'd0, wb_count}, 32'd0);
    step(); step();
    rst = 1'b1;

    // Single ALU write
    alu(4'd3, 32'h55, 1'b1);
    chk("alu_we", {31'd0, writeBackEn}, 32'd1);
    chk("alu_dest", {28'd0, Dest_wb}, 32'd3);
    chk("alu_data", Result_WB, 32'h55);
    step();
    chk("alu_pulse_end", {31'd0, writeBackEn}, 32'd0);
    chk("alu_hold", Result_WB, 32'h55);
    chk("alu_cnt", {28'd0, wb_count}, 32'd1);

    // Back-to-back at full throughput
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; WB_EN = 1'b1; MEM_R_EN = 1'b0; Dest = 4'(i); ALU_Res = 32'(9 + i);
      step();
      chk("b2b_we", {31'd0, writeBackEn}, 32'd1);
      chk("b2b_dest", {28'd0, Dest_wb}, 32'(i));
      chk("b2b_data", Result_WB, 32'(9 + i));
    end
    in_valid = 1'b0; WB_EN = 1'b0;
    step();
    chk("b2b_cnt", {28'd0, wb_count}, 32'd4);

    // Load returning after 5 cycles
    load(4'd7, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("ld_stall", {31'd0, in_ready}, 32'd0);
      step();
    end
    chk("ld_stall", {31'd0, in_ready}, 32'd0);
    mem_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_valid = 1'b0;
    chk("ld_we", {31'd0, writeBackEn}, 32'd1);
    chk("ld_dest", {28'd0, Dest_wb}, 32'd7);
    chk("ld_data", Result_WB, 32'hDEADBEEF);
    chk("ld_ready", {31'd0, in_ready}, 32'd1);

    // Data on the timeout edge wins
    load(4'd5, 1'b1);
    repeat (TMO - 1) step();
    chk("edge_stall", {31'd0, in_ready}, 32'd0);
    mem_valid = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_valid = 1'b0;
    chk("edge_we", {31'd0, writeBackEn}, 32'd1);
    chk("edge_data", Result_WB, 32'h12345678);
    chk("edge_err", {31'd0, load_err}, 32'd0);
    step();
    chk("edge_cnt", {28'd0, wb_count}, 32'd6);

    // Timeout, then late mem_valid ignored
    load(4'd9, 1'b1);
    repeat (TMO - 1) step();
    chk("tmo_pre_err", {31'd0, load_err}, 32'd0);
    step();
    chk("tmo_err", {31'd0, load_err}, 32'd1);
    chk("tmo_ready", {31'd0, in_ready}, 32'd1);
    chk("tmo_we", {31'd0, writeBackEn}, 32'd0);
    mem_valid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    step();
    mem_valid = 1'b0;
    chk("late_we", {31'd0, writeBackEn}, 32'd0);
    chk("late_data", Result_WB, 32'h12345678);

    // Bubble and non-writing load
    alu(4'd4, 32'h99, 1'b0);
    chk("bub_we", {31'd0, writeBackEn}, 32'd0);
    load(4'd6, 1'b0);
    step();
    mem_valid = 1'b1; mem_rdata = 32'h77;
    step();
    mem_valid = 1'b0;
    chk("nwld_we", {31'd0, writeBackEn}, 32'd0);
    chk("nwld_ready", {31'd0, in_ready}, 32'd1);
    chk("nwld_cnt", {28'd0, wb_count}, 32'd6);

    // Dest 15 is not filtered
    alu(4'd15, 32'hF00D, 1'b1);
    chk("d15_dest", {28'd0, Dest_wb}, 32'd15);
    chk("d15_we", {31'd0, writeBackEn}, 32'd1);

    // Reset in the middle of a load
    load(4'd2, 1'b1);
    step();
    #1 rst = 1'b0;
    #1;
    chk("mrst_we", {31'd0, writeBackEn}, 32'd0);
    chk("mrst_ready", {31'd0, in_ready}, 32'd1);
    chk("mrst_cnt", {28'd0, wb_count}, 32'd0);
    step();
    rst = 1'b1;
    mem_valid = 1'b1; mem_rdata = 32'hCAFE;
    step();
    mem_valid = 1'b0;
    chk("mrst_late_we", {31'd0, writeBackEn}, 32'd0);

    // Counter wrap: 17 writes in a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; WB_EN = 1'b1; MEM_R_EN = 1'b0; Dest = 4'(i); ALU_Res = 32'(i);
      step();
    end
    in_valid = 1'b0; WB_EN = 1'b0;
    step();
    chk("wrap_cnt", {28'd0, wb_count}, 32'd1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/wb_unit.md
# wb_unit

Write-back stage that drives the register file's write port (Dest_wb, Result_WB, writeBackEn). It accepts retiring instructions from the MEM stage, handles both ALU results and multi-cycle loads through a valid handshake, and stalls the pipeline while a load is outstanding. It also keeps a retired-write counter and flags lost loads.

## Interface
- LOAD_TIMEOUT, 255: maximum cycles spent in LOAD_WAIT before the load is abandoned (range 1..65535).
- CNT_W, 16: width of the retired-write counter.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept; pipeline stall = !in_ready.
- WB_EN  in  1  instruction writes a register.
- MEM_R_EN  in  1  instruction is a load.
- Dest  in  4  destination register index.
- ALU_Res  in  32  ALU result.
- mem_valid  in  1  load data valid (single-cycle pulse from memory controller).
- mem_rdata  in  32  load data.
- writeBackEn  out  1  register file write enable (registered).
- Dest_wb  out  4  write index (registered).
- Result_WB  out  32  write data (registered).
- load_err  out  1  sticky: a load timed out.
- wb_count  out  CNT_W  number of writeBackEn pulses issued.

## Operation
- FSM states: IDLE, LOAD_WAIT.
- IDLE: in_ready=1. On in_valid:
  - MEM_R_EN=0: capture Dest/ALU_Res and pulse writeBackEn=WB_EN next cycle; stay IDLE.
  - MEM_R_EN=1: latch Dest and WB_EN, clear the timeout counter, and go to LOAD_WAIT.
- LOAD_WAIT: in_ready=0. mem_valid is ignored outside LOAD_WAIT.
  - On mem_valid: Result_WB=mem_rdata, Dest_wb=latched Dest, writeBackEn=latched WB_EN for one cycle; go to IDLE.
  - Otherwise: increment the counter. If counter reaches LOAD_TIMEOUT, set load_err, issue no write, and go to IDLE.
- in_valid with WB_EN=0 and MEM_R_EN=0 is a bubble. It is accepted and produces no write.
- A load with WB_EN=0 still waits for mem_valid (or timeout), but issues no write.
- writeBackEn is a single-cycle pulse; it is never held across two instructions without re-acceptance.
- Dest_wb/Result_WB hold their last value when writeBackEn=0.
- wb_count increments on every cycle writeBackEn=1 and wraps modulo 2^CNT_W.
- load_err is cleared only by reset.
- Dest=15 is written like any other index; the stage does not filter it.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, writeBackEn=0, Dest_wb=0, Result_WB=0, load_err=0, wb_count=0, timeout counter=0. in_ready=1 combinationally after reset.
- ALU op accepted at edge N: writeBackEn=1 during cycle N..N+1 (visible after edge N). The register file samples it on the following negedge, giving 1-cycle write latency.
- Load accepted at edge N: in_ready=0 from edge N. mem_valid sampled at edge M≥N+1 → writeBackEn=1 after edge M; in_ready=1 after edge M. The next instruction can be accepted at edge M+1.
- Timeout: with no mem_valid, load_err rises after edge N+LOAD_TIMEOUT; in_ready returns to 1 at the same edge.
- mem_valid on the same edge as the timeout: the data wins, the write is issued, and load_err is not set.
- Back-to-back ALU ops: one write per cycle at full throughput.
- Reset asserted mid-LOAD_WAIT: outstanding load is dropped and writeBackEn=0 immediately. A late mem_valid after reset is ignored (state IDLE).

## Configuration
- WB_FORWARD_EN defined: adds outputs fwd_valid (1), fwd_dest (4), fwd_data (32).
  - These equal writeBackEn, Dest_wb, Result_WB, exported for the EXE-stage bypass mux.
  - fwd_valid resets to 0.
- WB_FORWARD_EN undefined: these ports do not exist; behaviour is otherwise identical.

## Test plan
- Reset: rst=0 mid-run → all outputs 0, in_ready=1; release, ALU op Dest=3, ALU_Res=0x55 → one-cycle writeBackEn, Dest_wb=3, Result_WB=0x55, wb_count=1.
- Three back-to-back ALU ops (Dest 1,2,3; data 0xA,0xB,0xC) → three consecutive writeBackEn pulses in order; wb_count=3.
- Load Dest=7, mem_valid after 5 cycles with 0xDEADBEEF → in_ready=0 for 5 cycles, then writeBackEn with Dest_wb=7, Result_WB=0xDEADBEEF.
- LOAD_TIMEOUT=4, load with no mem_valid → load_err=1 after 4 cycles, no writeBackEn; later mem_valid ignored.
- Bubble (WB_EN=0) and load with WB_EN=0 → no writeBackEn pulse, wb_count unchanged.
- CNT_W=4, 17 writes → wb_count=1 (wraps).
